restoring_divider_16: RTL and testbench

RESTORING_DIVIDER_16 -- requirements
Module: restoring_divider_16

---
 rtl/restoring_divider_16.sv | 153 +++++++++++++++
 tb/tb_restoring_divider_16.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_16.sv
// restoring_divider_16
// Multi-cycle radix-2 restoring divider with per-operand signed/unsigned
// selection. One quotient bit is resolved per ITER cycle. Results follow
// truncating division: the remainder carries the sign of the dividend.
// Divide-by-zero keeps the normal latency and returns all-ones / dividend.
module restoring_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sign_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam logic [4:0]       LAST_ITER = 5'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  // Two's-complement negate when neg is set, otherwise pass through.
  // Negating the most negative value wraps to itself, which is exactly the
  // truncated result wanted for the 0x8000 / -1 overflow case.
  function automatic logic [WIDTH-1:0] f_cond_negate(
    input logic [WIDTH-1:0] v,
    input logic             neg
  );
    f_cond_negate = neg ? (~v + ONE) : v;
  endfunction

  state_t             r_state;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [1:0]         r_mode;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_qshift;   // |a| shifts out of the top, quotient bits shift in
  logic [WIDTH-1:0]   r_prem;     // partial remainder (always < |b|)
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_zero;
  logic [4:0]         r_cnt;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_done;
  logic               r_dbz;

  logic               w_sa;
  logic               w_sb;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_take;

  // Effective sign bits of the captured operands under the captured mode.
  always_comb begin
    w_sa = r_mode[1] & r_dividend[WIDTH-1];
    w_sb = r_mode[0] & r_divisor[WIDTH-1];
  end

  // One restoring step: shift next dividend bit into the WIDTH+1-bit partial
  // remainder and trial-subtract |b|; a clear MSB means the subtraction fits.
  always_comb begin
    w_shift = {r_prem, r_qshift[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_mag_b};
    w_take  = ~w_trial[WIDTH];
  end

  // Control FSM with datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_mode      <= '0;
      r_mag_b     <= '0;
      r_qshift    <= '0;
      r_prem      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_mode     <= sign_mode;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          r_qshift <= f_cond_negate(r_dividend, w_sa);
          r_mag_b  <= f_cond_negate(r_divisor, w_sb);
          r_prem   <= '0;
          r_neg_q  <= w_sa ^ w_sb;
          r_neg_r  <= w_sa;
          r_zero   <= (r_divisor == '0);
          r_cnt    <= '0;
          r_state  <= ITER;
        end
        ITER: begin
          if (w_take) begin
            r_prem <= w_trial[WIDTH-1:0];
          end else begin
            r_prem <= w_shift[WIDTH-1:0];
          end
          r_qshift <= {r_qshift[WIDTH-2:0], w_take};
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == LAST_ITER) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_dividend;
            r_dbz       <= 1'b1;
          end else begin
            r_quotient  <= f_cond_negate(r_qshift, r_neg_q);
            r_remainder <= f_cond_negate(r_prem, r_neg_r);
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_restoring_divider_16.sv
// Scoreboard bench for restoring_divider_16: the driver pushes the expected
// result of every accepted start into a queue, and an independent monitor
// pops and compares whenever done is seen.
module tb_restoring_divider_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [1:0]  sign_mode;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  restoring_divider_16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign_mode   (sign_mode),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // count of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          e0;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
  endfunction

  // Reference: plain integer division (truncating toward zero, remainder
  // takes dividend sign) on the operands interpreted per sign_mode.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic [1:0] m, int e0);
    exp_t   x;
    longint av, bv, qv, rv;
    x.e0 = e0;
    if (b == 16'h0000) begin
      x.q  = 16'hFFFF;
      x.r  = a;
      x.dz = 1'b1;
    end else begin
      av = (m[1] && a[15]) ? longint'(a) - 65536 : longint'(a);
      bv = (m[0] && b[15]) ? longint'(b) - 65536 : longint'(b);
      qv = av / bv;
      rv = av % bv;
      x.q  = qv[15:0];
      x.r  = rv[15:0];
      x.dz = 1'b0;
    end
    return x;
  endfunction

  // ---------------- monitor ----------------
  logic [15:0] last_q = '0;
  logic [15:0] last_r = '0;
  int          busy_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_q   = '0;
      last_r   = '0;
      busy_cnt = 0;
    end else if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 q=0x%0h expected no pending result", quotient);
      end else begin
        e = sb_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
        check("latency", cyc, e.e0 + 18);
        check("busy_in_done", busy, 1'b0);
        check("busy_cycles", busy_cnt, 18);
        last_q = e.q;
        last_r = e.r;
      end
      busy_cnt = 0;
    end else begin
      check("dbz_without_done", div_by_zero, 1'b0);
      check("quotient_hold", quotient, last_q);
      check("remainder_hold", remainder, last_r);
      if (busy) busy_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(logic [15:0] a, logic [15:0] b, logic [1:0] m);
    dividend  = a;
    divisor   = b;
    sign_mode = m;
    start     = 1'b1;
    sb_q.push_back(model(a, b, m, cyc + 1));
    tick();
    start = 1'b0;
  endtask

  task automatic poke(logic [15:0] a, logic [15:0] b, logic [1:0] m);
    dividend  = a;
    divisor   = b;
    sign_mode = m;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    check("drain_pending", sb_q.size(), 0);
  endtask

  task automatic run(logic [15:0] a, logic [15:0] b, logic [1:0] m);
    issue(a, b, m);
    drain();
    tick();
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          sel;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    sign_mode = '0;
    repeat (3) tick();
    check("rst_quotient", quotient, 16'h0);
    check("rst_remainder", remainder, 16'h0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;
    tick();

    // basic unsigned and signed cases
    run(16'd1000, 16'd7, 2'b00);
    run(16'hFFF9, 16'h0002, 2'b11);
    run(16'hFFF9, 16'h0002, 2'b00);
    for (int m = 0; m < 4; m++) run(16'h1234, 16'h0000, 2'(m));
    run(16'h8000, 16'hFFFF, 2'b11);
    run(16'h8000, 16'hFFFF, 2'b00);
    run(16'hFF00, 16'h0010, 2'b10);
    run(16'h0064, 16'hFFFD, 2'b01);

    // start during ITER with different operands must be ignored
    issue(16'd5000, 16'd9, 2'b00);
    repeat (5) tick();
    poke(16'hABCD, 16'h0003, 2'b11);
    drain();

    // back-to-back: start issued in the done cycle of the previous op
    issue(16'd777, 16'd10, 2'b00);
    for (int i = 0; i < 40 && !done; i++) tick();
    check("b2b_done_seen", done, 1'b1);
    issue(16'hFFF0, 16'h0003, 2'b11);
    drain();
    tick();

    // reset mid-iteration aborts without a done pulse
    issue(16'd4321, 16'd5, 2'b00);
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", quotient, 16'h0);
    check("midrst_remainder", remainder, 16'h0);
    check("midrst_done", done, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_dbz", div_by_zero, 1'b0);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    run(16'd1000, 16'd7, 2'b00);

    // randomized operands with corner values mixed in
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      rb  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'h0001 : 16'($urandom);
      sel = $urandom_range(0, 7);
      ra  = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h0000 : 16'($urandom);
      issue(ra, rb, 2'($urandom_range(0, 3)));
      drain();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
